// File: rtl/ripple_acc_pkg.sv
// Shared types and defaults for the ripple accumulator: FSM state encoding,
// default widths and a single-bit full-adder helper used by the adder slice.
package ripple_acc_pkg;

  localparam int WIDTH_DEF   = 3;
  localparam int COUNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_e;

  // Returns {carry_out, sum} of a single full-adder cell.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (c & (a ^ b));
    return {co, s};
  endfunction

endpackage

// File: rtl/rca_nbit.sv
// Parameterised combinational ripple-carry adder: a WIDTH-long chain of
// full-adder cells with explicit carry-in and carry-out.
module rca_nbit
  import ripple_acc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic [1:0] cell_s;
    assign cell_s       = full_add(a[i], b[i], carry_s[i]);
    assign sum[i]       = cell_s[0];
    assign carry_s[i+1] = cell_s[1];
  end

  assign cout = carry_s[WIDTH];

endmodule

// File: rtl/ripple_accumulator.sv
// Packet accumulator: sums valid/ready operand beats up to in_last and offers
// sum, sticky carry and saturating beat count. ACC_SATURATE_EN clamps the sum.
module ripple_accumulator
  import ripple_acc_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_carry,
  output logic [COUNT_W-1:0] out_count
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  acc_state_e         state_r;
  acc_state_e         next_state_s;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               in_ready_next_s;
  logic               out_valid_next_s;
  logic [WIDTH-1:0]   acc_r;
  logic               carry_r;
  logic [COUNT_W-1:0] count_r;
  logic [WIDTH-1:0]   sum_s;
  logic               cout_s;
  logic [WIDTH-1:0]   acc_next_s;
  logic [COUNT_W-1:0] count_next_s;
  logic               beat_fire_s;
  logic               result_fire_s;

  assign beat_fire_s   = in_valid & in_ready_r;
  assign result_fire_s = out_valid_r & out_ready;

  rca_nbit #(
    .WIDTH (WIDTH)
  ) u_rca (
    .a    (acc_r),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // State register plus the handshake flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= in_ready_next_s;
      out_valid_r <= out_valid_next_s;
    end
  end

  // Next-state logic for the packet FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_ACC: begin
        if (beat_fire_s) begin
          next_state_s = in_last ? ST_DONE : ST_ACC;
        end else begin
          next_state_s = state_r;
        end
      end
      ST_DONE: begin
        if (result_fire_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Handshake decode; flags are registered, so they depend on state only.
  always_comb begin
    in_ready_next_s  = 1'b0;
    out_valid_next_s = 1'b0;
    case (next_state_s)
      ST_IDLE, ST_ACC: begin
        in_ready_next_s  = 1'b1;
        out_valid_next_s = 1'b0;
      end
      ST_DONE: begin
        in_ready_next_s  = 1'b0;
        out_valid_next_s = 1'b1;
      end
      default: begin
        in_ready_next_s  = 1'b0;
        out_valid_next_s = 1'b0;
      end
    endcase
  end

  // Next accumulator value: plain wrap or clamp to all-ones once carried.
  always_comb begin
    acc_next_s = sum_s;
`ifdef ACC_SATURATE_EN
    if (carry_r | cout_s) begin
      acc_next_s = {WIDTH{1'b1}};
    end else begin
      acc_next_s = sum_s;
    end
`else
    acc_next_s = sum_s;
`endif
  end

  // Beat counter increments but holds once it reaches all-ones.
  always_comb begin
    count_next_s = count_r;
    if (count_r == COUNT_MAX) begin
      count_next_s = count_r;
    end else begin
      count_next_s = count_r + COUNT_ONE;
    end
  end

  // Datapath registers; the result handshake clears them for the next packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      count_r <= {COUNT_W{1'b0}};
    end else if (result_fire_s) begin
      acc_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      count_r <= {COUNT_W{1'b0}};
    end else if (beat_fire_s) begin
      acc_r   <= acc_next_s;
      carry_r <= carry_r | cout_s;
      count_r <= count_next_s;
    end else begin
      acc_r   <= acc_r;
      carry_r <= carry_r;
      count_r <= count_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = acc_r;
  assign out_carry = carry_r;
  assign out_count = count_r;

endmodule

// File: tb/tb_ripple_accumulator.sv
// Self-checking bench for ripple_accumulator (WIDTH=3, COUNT_W=4): vector table,
// hand-written corner sequences and randomized packets against an arithmetic model.
module tb_ripple_accumulator;

  localparam int W  = 3;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_carry;
  logic [CW-1:0] out_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0][2:0] beats;
    logic [2:0]      n;
    logic [2:0]      sum;
    logic            carry;
    logic [3:0]      count;
  } vec_t;

  vec_t tbl [8];

  ripple_accumulator #(
    .WIDTH   (W),
    .COUNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int b0, input int b1, input int b2, input int b3,
                              input int n, input int s, input int c, input int cnt);
    vec_t v;
    v.beats[0] = 3'(b0);
    v.beats[1] = 3'(b1);
    v.beats[2] = 3'(b2);
    v.beats[3] = 3'(b3);
    v.n        = 3'(n);
    v.sum      = 3'(s);
    v.carry    = 1'(c);
    v.count    = 4'(cnt);
    return v;
  endfunction

  // Leaves in_valid high after the accepting edge; caller decides what follows.
  task automatic push_beat(input logic [W-1:0] d, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Called the cycle right after the last beat: checks latency, hold, result, return to IDLE.
  task automatic get_result(input int es, input int ec, input int ecnt, input int hold,
                            input string name);
    chk({name, "_latency_valid"}, int'(out_valid), 1);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      chk({name, "_hold_in_ready"}, int'(in_ready), 0);
      chk({name, "_hold_valid"}, int'(out_valid), 1);
      chk({name, "_hold_sum"}, int'(out_sum), es);
      @(posedge clk); #1;
    end
    chk({name, "_sum"}, int'(out_sum), es);
    chk({name, "_carry"}, int'(out_carry), ec);
    chk({name, "_count"}, int'(out_count), ecnt);
    chk({name, "_done_in_ready"}, int'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_idle_valid"}, int'(out_valid), 0);
    chk({name, "_idle_in_ready"}, int'(in_ready), 1);
  endtask

  logic [2:0] bb_d [6];
  logic       bb_l [6];
  int         bb_s [3];
  int         bb_c [3];
  int         bb_n [3];

  initial begin
    int total;
    int n;
    int es;
    int ec;
    int ecnt;
    int idx;
    int ri;
    int stall;
    int cyc;
    logic [W-1:0] d;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 3'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    tbl[0] = mk(2, 3, 1, 0, 3, 6, 0, 3);
`ifdef ACC_SATURATE_EN
    tbl[1] = mk(5, 4, 0, 0, 2, 7, 1, 2);
    tbl[4] = mk(7, 7, 7, 7, 4, 7, 1, 4);
    tbl[7] = mk(6, 3, 1, 0, 3, 7, 1, 3);
`else
    tbl[1] = mk(5, 4, 0, 0, 2, 1, 1, 2);
    tbl[4] = mk(7, 7, 7, 7, 4, 4, 1, 4);
    tbl[7] = mk(6, 3, 1, 0, 3, 2, 1, 3);
`endif
    tbl[2] = mk(7, 0, 0, 0, 1, 7, 0, 1);
    tbl[3] = mk(0, 0, 0, 0, 1, 0, 0, 1);
    tbl[5] = mk(1, 1, 1, 1, 4, 4, 0, 4);
    tbl[6] = mk(3, 4, 0, 0, 2, 7, 0, 2);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_sum", int'(out_sum), 0);
    chk("reset_carry", int'(out_carry), 0);
    chk("reset_count", int'(out_count), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int t = 0; t < 8; t++) begin
      for (int b = 0; b < int'(tbl[t].n); b++) begin
        push_beat(tbl[t].beats[b], b == int'(tbl[t].n) - 1);
      end
      in_valid = 1'b0;
      get_result(int'(tbl[t].sum), int'(tbl[t].carry), int'(tbl[t].count), 0, $sformatf("tbl%0d", t));
    end

    // Backpressure with the next beat already held by the source
    push_beat(3'd7, 1'b1);
    in_data = 3'd3;
    in_last = 1'b1;
    get_result(7, 0, 1, 5, "bp");
    chk("bp_held_beat_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    get_result(3, 0, 1, 0, "bp_next");

    // Count saturation: 20 zeros then 1
    for (int b = 0; b < 20; b++) push_beat(3'd0, 1'b0);
    push_beat(3'd1, 1'b1);
    in_valid = 1'b0;
    get_result(1, 0, 15, 0, "sat_count");

    // Reset mid-packet
    push_beat(3'd6, 1'b0);
    push_beat(3'd6, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_sum", int'(out_sum), 0);
    chk("midrst_count", int'(out_count), 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_result", int'(out_valid), 0);
    push_beat(3'd1, 1'b1);
    in_valid = 1'b0;
    get_result(1, 0, 1, 0, "midrst_next");

    // Back-to-back packets, in_valid and out_ready continuously high
    bb_d[0] = 3'd1; bb_l[0] = 1'b0;
    bb_d[1] = 3'd2; bb_l[1] = 1'b1;
    bb_d[2] = 3'd3; bb_l[2] = 1'b1;
    bb_d[3] = 3'd4; bb_l[3] = 1'b0;
    bb_d[4] = 3'd2; bb_l[4] = 1'b0;
    bb_d[5] = 3'd1; bb_l[5] = 1'b1;
    bb_s[0] = 3; bb_c[0] = 0; bb_n[0] = 2;
    bb_s[1] = 3; bb_c[1] = 0; bb_n[1] = 1;
    bb_s[2] = 7; bb_c[2] = 0; bb_n[2] = 3;
    idx = 0; ri = 0; stall = 0; cyc = 0;
    out_ready = 1'b1;
    while ((idx < 6 || ri < 3) && cyc < 100) begin
      if (idx < 6) begin
        in_valid = 1'b1;
        in_data  = bb_d[idx];
        in_last  = bb_l[idx];
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (ri < 3) begin
          chk($sformatf("b2b%0d_sum", ri), int'(out_sum), bb_s[ri]);
          chk($sformatf("b2b%0d_carry", ri), int'(out_carry), bb_c[ri]);
          chk($sformatf("b2b%0d_count", ri), int'(out_count), bb_n[ri]);
        end else begin
          chk("b2b_extra_result", ri, 2);
        end
        ri++;
      end
      if (!in_ready) stall++;
      if (in_ready && idx < 6) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_results", ri, 3);
    chk("b2b_stall_cycles", stall, 3);
    chk("b2b_end_valid", int'(out_valid), 0);

    // Randomized packets against an arithmetic model of the packet result
    for (int p = 0; p < 40; p++) begin
      n = (p % 8 == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(1, 6));
      total = 0;
      for (int b = 0; b < n; b++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        d = W'($urandom_range(0, 7));
        total += int'(d);
        push_beat(d, b == n - 1);
      end
      in_valid = 1'b0;
      ec = (total >= (1 << W)) ? 1 : 0;
`ifdef ACC_SATURATE_EN
      es = (ec != 0) ? ((1 << W) - 1) : total;
`else
      es = total % (1 << W);
`endif
      ecnt = (n > 15) ? 15 : n;
      get_result(es, ec, ecnt, int'($urandom_range(0, 3)), $sformatf("rnd%0d", p));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
